// File: rtl/pe_conv_arbiter.sv
// rtl/pe_conv_arbiter.sv - round-robin arbiter sharing one conversion PE among requesters
//
// Purpose: picks one requester per issue (round-robin, locked while the PE
// stalls), drives the shared PE operand channels, tracks issuing requester
// indices in an in-order tag FIFO and routes each PE result back.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   req_valid/req_ready         per-requester operand-pair handshake
//   req_a_data/req_b_data       packed operands, requester i at [i*W +: W]
//   rsp_valid/rsp_ready         per-requester result handshake
//   rsp_data                    shared result bus, qualified by rsp_valid
//   pe_in0_*/pe_in1_*           PE operand A/B channels (valids always equal)
//   pe_out_*                    PE result channel
//   busy                        tag FIFO non-empty
//   stat_issue_cnt/stat_stall_cnt  saturating counters, only with PE_CONV_ARB_STATS_EN
module pe_conv_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 32,
    parameter int R_WIDTH   = 16,
    parameter int TAG_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0]   req_a_data,
    input  logic [NUM_REQ*B_WIDTH-1:0]   req_b_data,
    output logic [NUM_REQ-1:0]           rsp_valid,
    input  logic [NUM_REQ-1:0]           rsp_ready,
    output logic [R_WIDTH-1:0]           rsp_data,
    output logic                         pe_in0_valid,
    input  logic                         pe_in0_ready,
    output logic [A_WIDTH-1:0]           pe_in0_data,
    output logic                         pe_in1_valid,
    input  logic                         pe_in1_ready,
    output logic [B_WIDTH-1:0]           pe_in1_data,
    input  logic                         pe_out_valid,
    output logic                         pe_out_ready,
    input  logic [R_WIDTH-1:0]           pe_out_data,
    output logic                         busy
`ifdef PE_CONV_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]        stat_issue_cnt,
    output logic [31:0]                  stat_stall_cnt
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] locked_idx;
    logic             lock;
    logic [IDX_W-1:0] grant_idx;
    logic             any_grant;
    logic             issue_valid;
    logic             fire;
    logic             pop;
    int               cand;

    logic [IDX_W-1:0] tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_full;
    logic             fifo_empty;
    logic [IDX_W-1:0] head_tag;

    // Grant: a locked grant holds the PE inputs stable until they transfer;
    // otherwise the lowest offset from rr_ptr wins (scan high-to-low so the
    // last overwrite is the nearest candidate).
    always_comb begin
        grant_idx = rr_ptr;
        any_grant = 1'b0;
        cand      = 0;
        if (lock) begin
            grant_idx = locked_idx;
            any_grant = 1'b1;
        end else begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                cand = int'(rr_ptr) + k;
                if (cand >= NUM_REQ) begin
                    cand = cand - NUM_REQ;
                end
                if (req_valid[cand]) begin
                    grant_idx = IDX_W'(cand);
                    any_grant = 1'b1;
                end
            end
        end
    end

    assign fifo_full   = (count == CNT_W'(TAG_DEPTH));
    assign fifo_empty  = (count == '0);
    // Gating with rst_n keeps the issue channel quiet while reset is held.
    assign issue_valid = rst_n & any_grant & ~fifo_full;
    assign fire        = issue_valid & pe_in0_ready & pe_in1_ready;

    assign pe_in0_valid = issue_valid;
    assign pe_in1_valid = issue_valid;
    assign pe_in0_data  = issue_valid ? req_a_data[grant_idx*A_WIDTH +: A_WIDTH] : '0;
    assign pe_in1_data  = issue_valid ? req_b_data[grant_idx*B_WIDTH +: B_WIDTH] : '0;

    always_comb begin
        req_ready = '0;
        if (fire) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Return path: results come back in issue order, so the FIFO head names
    // the only requester that can own the current PE result.
    assign head_tag = tag_mem[rd_ptr];

    always_comb begin
        rsp_valid    = '0;
        pe_out_ready = 1'b0;
        if (!fifo_empty) begin
            rsp_valid[head_tag] = pe_out_valid;
            pe_out_ready        = rsp_ready[head_tag];
        end
    end

    assign rsp_data = pe_out_data;
    assign pop      = pe_out_valid & pe_out_ready;
    assign busy     = ~fifo_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            lock       <= 1'b0;
            locked_idx <= '0;
        end else if (fire) begin
            lock   <= 1'b0;
            rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end else if (issue_valid) begin
            lock       <= 1'b1;
            locked_idx <= grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(fire) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (fire) begin
            tag_mem[wr_ptr] <= grant_idx;
        end
    end

`ifdef PE_CONV_ARB_STATS_EN
    logic [31:0] issue_cnt [NUM_REQ];
    logic [31:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                issue_cnt[i] <= '0;
            end
            stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (fire && grant_idx == IDX_W'(i) && issue_cnt[i] != 32'hFFFF_FFFF) begin
                    issue_cnt[i] <= issue_cnt[i] + 32'd1;
                end
            end
            if (|req_valid && !fire && stall_cnt != 32'hFFFF_FFFF) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
        assign stat_issue_cnt[gi*32 +: 32] = issue_cnt[gi];
    end
    assign stat_stall_cnt = stall_cnt;
`endif

endmodule

// File: tb/tb_pe_conv_arbiter.sv
// tb/tb_pe_conv_arbiter.sv - self-checking bench for pe_conv_arbiter
module tb_pe_conv_arbiter;

    localparam int N  = 2;
    localparam int AW = 16;
    localparam int BW = 32;
    localparam int RW = 16;
    localparam int TD = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*AW-1:0] req_a_data;
    logic [N*BW-1:0] req_b_data;
    logic [RW-1:0]   rsp_data;
    logic            pe_in0_valid, pe_in0_ready, pe_in1_valid, pe_in1_ready;
    logic [AW-1:0]   pe_in0_data;
    logic [BW-1:0]   pe_in1_data;
    logic            pe_out_valid, pe_out_ready;
    logic [RW-1:0]   pe_out_data;
    logic            busy;
`ifdef PE_CONV_ARB_STATS_EN
    logic [N*32-1:0] stat_issue_cnt;
    logic [31:0]     stat_stall_cnt;
`endif

    always #5 clk = ~clk;

    pe_conv_arbiter #(.NUM_REQ(N), .A_WIDTH(AW), .B_WIDTH(BW), .R_WIDTH(RW), .TAG_DEPTH(TD)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a_data(req_a_data), .req_b_data(req_b_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .pe_in0_valid(pe_in0_valid), .pe_in0_ready(pe_in0_ready), .pe_in0_data(pe_in0_data),
        .pe_in1_valid(pe_in1_valid), .pe_in1_ready(pe_in1_ready), .pe_in1_data(pe_in1_data),
        .pe_out_valid(pe_out_valid), .pe_out_ready(pe_out_ready), .pe_out_data(pe_out_data),
        .busy(busy)
`ifdef PE_CONV_ARB_STATS_EN
        , .stat_issue_cnt(stat_issue_cnt), .stat_stall_cnt(stat_stall_cnt)
`endif
    );

    typedef struct {
        int            req;
        logic [RW-1:0] res;
    } ent_t;

    typedef struct {
        logic [N-1:0]  rv;
        logic [RW-1:0] data;
    } pop_t;

    int n_chk  = 0;
    int n_fail = 0;

    // requester side: each holds one pending operation until accepted
    logic          rv [N];
    logic [AW-1:0] ra [N];
    logic [BW-1:0] rb [N];

    // reference model: arbitration pointer, lock, and in-flight operations
    // (the bench PE returns a + b truncated, in order)
    int   rr;
    int   locked;
    ent_t q[$];
    int   issued [N];
    int   stalls;

    // observations of the DUT, used by directed checks
    int   fires_obs;
    int   fire_log[$];
    pop_t pop_log[$];

    int   in0_pct, in1_pct, rsp_pct, out_pct, gen_pct;
    bit   stray;
    logic rst_next;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        int           g;
        bit           found, iv, fire, pop, nonempty;
        int           h;
        logic [N-1:0] e_rdy, e_rsp;
        @(negedge clk);
        rst_n = rst_next;
        for (int i = 0; i < N; i++) begin
            if (!rv[i] && $urandom_range(99) < gen_pct) begin
                rv[i] = 1'b1;
                ra[i] = AW'($urandom);
                rb[i] = $urandom;
            end
            req_valid[i]           = rv[i];
            req_a_data[i*AW +: AW] = ra[i];
            req_b_data[i*BW +: BW] = rb[i];
            rsp_ready[i]           = ($urandom_range(99) < rsp_pct);
        end
        pe_in0_ready = ($urandom_range(99) < in0_pct);
        pe_in1_ready = ($urandom_range(99) < in1_pct);
        if (stray) begin
            pe_out_valid = 1'b1;
            pe_out_data  = RW'($urandom);
        end else begin
            pe_out_valid = (q.size() > 0) && ($urandom_range(99) < out_pct);
            pe_out_data  = pe_out_valid ? q[0].res : '0;
        end
        #1;
        found = 0;
        g     = 0;
        if (locked >= 0) begin
            found = 1;
            g     = locked;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!found && rv[(rr + k) % N]) begin
                    found = 1;
                    g     = (rr + k) % N;
                end
            end
        end
        iv       = rst_n && found && (q.size() < TD);
        fire     = iv && pe_in0_ready && pe_in1_ready;
        nonempty = (q.size() > 0);
        h        = nonempty ? q[0].req : 0;
        e_rdy    = '0;
        e_rsp    = '0;
        if (fire) e_rdy[g] = 1'b1;
        if (nonempty && pe_out_valid) e_rsp[h] = 1'b1;
        pop = nonempty && pe_out_valid && rsp_ready[h];

        chk("pe_in0_valid", pe_in0_valid, iv);
        chk("pe_in1_valid", pe_in1_valid, iv);
        chk("pe_in0_data", pe_in0_data, iv ? ra[g] : '0);
        chk("pe_in1_data", pe_in1_data, iv ? rb[g] : '0);
        chk("req_ready", req_ready, e_rdy);
        chk("rsp_valid", rsp_valid, e_rsp);
        chk("pe_out_ready", pe_out_ready, nonempty && rsp_ready[h]);
        chk("busy", busy, nonempty);
        if (e_rsp != '0) chk("rsp_data", rsp_data, q[0].res);

        if (|req_ready) begin
            fires_obs++;
            for (int i = 0; i < N; i++) if (req_ready[i]) fire_log.push_back(i);
        end
        if (pe_out_valid && pe_out_ready) pop_log.push_back('{rsp_valid, rsp_data});

        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            locked = -1;
            rr     = 0;
            stalls = 0;
            for (int i = 0; i < N; i++) issued[i] = 0;
        end else begin
            if (rsp_valid != '0 || rv[0] || rv[1]) begin
                if ((rv[0] || rv[1]) && !fire) stalls++;
            end
            if (pop) void'(q.pop_front());
            if (fire) begin
                q.push_back('{g, RW'(ra[g] + rb[g][RW-1:0])});
                rr     = (g + 1) % N;
                locked = -1;
                rv[g]  = 1'b0;
                issued[g]++;
            end else if (iv) begin
                locked = g;
            end
        end
    endtask

    task automatic set_pct(input int i0, input int i1, input int rs, input int ou, input int ge);
        in0_pct = i0; in1_pct = i1; rsp_pct = rs; out_pct = ou; gen_pct = ge;
    endtask

    task automatic drain(input string tag);
        set_pct(100, 100, 100, 100, 0);
        for (int i = 0; i < 40 && (q.size() > 0 || rv[0] || rv[1]); i++) step();
        #2;
        chk(tag, busy, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; rst_next = 1'b0; stray = 0;
        req_valid = '0; req_a_data = '0; req_b_data = '0; rsp_ready = '0;
        pe_in0_ready = 1'b0; pe_in1_ready = 1'b0; pe_out_valid = 1'b0; pe_out_data = '0;
        rr = 0; locked = -1; stalls = 0; fires_obs = 0;
        for (int i = 0; i < N; i++) begin rv[i] = 1'b0; ra[i] = '0; rb[i] = '0; issued[i] = 0; end

        // reset held three cycles with everything ready
        set_pct(100, 100, 100, 100, 0);
        for (int i = 0; i < 3; i++) step();
        #2;
        chk("reset_busy", busy, 1'b0);
        chk("reset_pe_in0_valid", pe_in0_valid, 1'b0);
        chk("reset_rsp_valid", rsp_valid, 2'b00);
        rst_next = 1'b1;

        // single requester: 3 + 5 = 8 routed to requester 0
        pop_log.delete(); fire_log.delete();
        rv[0] = 1'b1; ra[0] = 16'd3; rb[0] = 32'd5;
        step();
        chk("single_fire_same_cycle", fire_log.size(), 1);
        drain("single_drain");
        chk("single_pops", pop_log.size(), 1);
        if (pop_log.size() > 0) begin
            chk("single_rsp_valid", pop_log[0].rv, 2'b01);
            chk("single_rsp_data", pop_log[0].data, 16'd8);
        end

        // round-robin: both continuously valid, grants alternate
        fire_log.delete();
        set_pct(100, 100, 100, 100, 100);
        for (int i = 0; i < 4; i++) step();
        chk("rr_fires", fire_log.size(), 4);
        for (int i = 1; i < 4 && i < fire_log.size(); i++)
            chk("rr_alternate", fire_log[i], 1 - fire_log[i-1]);
        drain("rr_drain");

        // lock: req1 stalled three cycles while req0 competes
        pop_log.delete(); fire_log.delete();
        set_pct(100, 0, 100, 100, 0);
        rv[1] = 1'b1; ra[1] = 16'hFFFF; rb[1] = 32'd1;
        step();
        chk("lock_data_a", pe_in0_data, 16'hFFFF);
        rv[0] = 1'b1; ra[0] = 16'h1234; rb[0] = 32'h10;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("lock_data_a_held", pe_in0_data, 16'hFFFF);
            chk("lock_data_b_held", pe_in1_data, 32'd1);
        end
        in1_pct = 100;
        step();
        chk("lock_fire_req1", req_ready, 2'b10);
        drain("lock_drain");
        if (pop_log.size() > 0) begin
            chk("lock_rsp_valid", pop_log[0].rv, 2'b10);
            chk("lock_rsp_data", pop_log[0].data, 16'd0);
        end

        // full FIFO under result backpressure, then drain in order
        fires_obs = 0;
        set_pct(100, 100, 0, 100, 100);
        for (int i = 0; i < 8; i++) step();
        chk("full_fires", fires_obs, TD);
        chk("full_no_issue", pe_in0_valid, 1'b0);
        chk("full_out_ready", pe_out_ready, 1'b0);
        for (int i = 0; i < N; i++) rv[i] = 1'b0;
        drain("full_drain");

        // PE result while nothing is in flight is neither consumed nor routed
        set_pct(100, 100, 100, 100, 0);
        stray = 1;
        step();
        chk("stray_out_ready", pe_out_ready, 1'b0);
        chk("stray_rsp_valid", rsp_valid, 2'b00);
        stray = 0;

        // mid-operation reset with three in flight
        set_pct(100, 100, 0, 100, 100);
        for (int i = 0; i < 20 && q.size() < 3; i++) step();
        chk("midrst_inflight", busy, 1'b1);
        for (int i = 0; i < N; i++) rv[i] = 1'b0;
        set_pct(100, 100, 100, 100, 0);
        rst_next = 1'b0;
        step();
        step();
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_rsp_valid", rsp_valid, 2'b00);
        rst_next = 1'b1;
        pop_log.delete();
        rv[1] = 1'b1; ra[1] = 16'h8000; rb[1] = 32'd0;
        drain("midrst_drain");
        chk("midrst_pops", pop_log.size(), 1);
        if (pop_log.size() > 0) begin
            chk("midrst_rsp_valid1", pop_log[0].rv, 2'b10);
            chk("midrst_rsp_data", pop_log[0].data, 16'h8000);
        end

        // randomized traffic against the model
        set_pct(60, 60, 50, 60, 40);
        for (int i = 0; i < 1500; i++) step();
        set_pct(70, 70, 70, 70, 0);
        drain("random_drain");

`ifdef PE_CONV_ARB_STATS_EN
        for (int i = 0; i < N; i++) chk("stat_issue_cnt", stat_issue_cnt[i*32 +: 32], 32'(issued[i]));
        chk("stat_stall_cnt", stat_stall_cnt, 32'(stalls));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_conv_arbiter.md
Name: pe_conv_arbiter

Overview:
- Shares one mixed-width conversion PE (operands i16 + i32, result i16) among NUM_REQ requesters.
- Each requester presents an operand pair. The block picks one requester per issue by round-robin and drives the PE inputs.
- It records the issuing requester's index in an in-order tag FIFO and routes each PE result back to that requester.
- It sits between requester PEs/ports and the shared conversion PE in the fabric.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- A_WIDTH, 16, operand A (PE in0) width.
- B_WIDTH, 32, operand B (PE in1) width.
- R_WIDTH, 16, result width.
- TAG_DEPTH, 4, maximum in-flight operations (power of 2, ≥2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_REQ  per-requester operand-pair valid.
- req_ready  out  NUM_REQ  per-requester accept.
- req_a_data  in  NUM_REQ*A_WIDTH  operand A, requester i at [i*A_WIDTH +: A_WIDTH].
- req_b_data  in  NUM_REQ*B_WIDTH  operand B, packed as above.
- rsp_valid  out  NUM_REQ  per-requester result valid.
- rsp_ready  in  NUM_REQ  per-requester result accept.
- rsp_data  out  R_WIDTH  result, shared by all requesters; qualified by rsp_valid.
- pe_in0_valid / pe_in0_ready / pe_in0_data  out/in/out  1/1/A_WIDTH  PE operand A channel.
- pe_in1_valid / pe_in1_ready / pe_in1_data  out/in/out  1/1/B_WIDTH  PE operand B channel.
- pe_out_valid / pe_out_ready / pe_out_data  in/out/in  1/1/R_WIDTH  PE result channel.
- busy  out  1  high when the tag FIFO is non-empty.

Behaviour:
- Reset: one clock domain (clk); rst_n is synchronous and active-low.
  - On reset: rr_ptr=0, lock cleared, tag FIFO empty.
  - All outputs are 0 on the cycle after rst_n is sampled low: req_ready, rsp_valid, pe_in*_valid, pe_out_ready, busy.
- Grant:
  - If lock is clear, grant goes to the first valid requester searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - If lock is set, grant is locked_idx, regardless of the other requesters.
- Issue:
  - pe_in0_valid = pe_in1_valid = (any grant) & !fifo_full. The two valids are always identical and never depend on any ready.
  - pe_in0_data/pe_in1_data carry the granted requester's operands. They are 0 when there is no valid.
  - fire = pe_in0_valid & pe_in0_ready & pe_in1_ready. The PE joins its inputs, so a transfer occurs only on fire.
  - req_ready[g] = fire for the granted g. All other req_ready bits are 0.
  - Latency from request to PE input is combinational (0 cycles).
- Lock: if valid is asserted without fire, set lock and locked_idx=g at the clock edge. This keeps the PE inputs stable. Clear lock on fire.
- Round-robin: on fire, rr_ptr <= (g+1) mod NUM_REQ. rr_ptr is unchanged otherwise.
- Tag FIFO:
  - Depth TAG_DEPTH, width clog2(NUM_REQ).
  - Push g on fire; pop on result fire.
  - fifo_full comes from the registered count, with no pop-to-push bypass. When full, a same-cycle pop does not enable a push.
  - Simultaneous push and pop when neither full nor empty: count is unchanged.
  - Pointers wrap modulo TAG_DEPTH.
- Return path:
  - h = FIFO head tag.
  - rsp_valid[h] = pe_out_valid & !fifo_empty. All other rsp_valid bits are 0.
  - rsp_data = pe_out_data.
  - pe_out_ready = !fifo_empty & rsp_ready[h].
  - Result fire (pop) = pe_out_valid & pe_out_ready.
  - Results are returned strictly in issue order.
- pe_out_valid while the FIFO is empty: pe_out_ready stays 0 and the result is neither consumed nor routed.
- Reset mid-operation: the FIFO is flushed and lock/rr_ptr cleared. The shared PE is on the same rst_n, so no stale results remain.
- Request protocol: a requester holds valid and data stable until its req_ready pulse. Withdrawing a locked request is a protocol violation.

Optional Feature:
PE_CONV_ARB_STATS_EN:
- Defined:
  - Adds output stat_issue_cnt (NUM_REQ*32): per-requester saturating count of fires.
  - Adds output stat_stall_cnt (32): saturating count of cycles with any req_valid high and no fire.
  - Both counters reset to 0 and saturate at 32'hFFFF_FFFF.
- Undefined: neither port exists and there is no counter logic. Arbitration behaviour is identical either way.

Test Plan:
- Reset: after 3 cycles with rst_n=0, every output is 0 and busy=0.
- Single requester:
  - Stimulus: req0 a=16'd3, b=32'd5; PE readies high.
  - Response: fire in the same cycle; PE returns 16'd8; rsp_valid[0]=1, rsp_data=8, rsp_valid[1]=0.
- Round-robin:
  - Stimulus: req0 and req1 both continuously valid with all readies high.
  - Response: grants go 0,1,0,1; stat_issue_cnt equals 2/2 after 4 fires (with PE_CONV_ARB_STATS_EN).
- Lock:
  - Stimulus: req1 granted with pe_in1_ready=0 for 3 cycles; req0 raises valid during that time.
  - Response: pe_in*_data stays on req1 (e.g. a=16'hFFFF, b=32'd1). When ready rises, fire goes to req1, and the result 16'd0 is routed to req1.
- Full FIFO / backpressure:
  - Stimulus: TAG_DEPTH=4, rsp_ready=0.
  - Response: exactly 4 fires, then pe_in*_valid=0 and pe_out_ready=0. Raising rsp_ready drains 4 results in issue order, and issue resumes the cycle after the count drops.
- Mid-operation reset:
  - Stimulus: assert rst_n=0 with 3 in flight.
  - Response: busy=0 and all valids are 0 the next cycle. A subsequent req1 with a=16'h8000, b=32'd0 returns 16'h8000 on rsp_valid[1].
